// File: rtl/axi_burst_slave_mem.sv
// Burst responder for the 8-bit AXI-style bus, backed by a 256x8 scratch memory.
// Write and read channels run as independent FSMs sharing the same storage.
module axi_burst_slave_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              a_rst,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [11:0]       AWADDR,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic [DATA_W-1:0] WDATA,
   input  logic              WLAST,
   output logic              BVALID,
   input  logic              BREADY,
   output logic              BRESP,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [11:0]       ARADDR,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic              RLAST,
   output logic [1:0]        wstate,
   output logic              rstate
);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic [1:0] w_state;
   logic [7:0] w_base;
   logic [4:0] w_len;
   logic [4:0] w_cnt;
   logic       wr_en;
   logic [7:0] wr_addr;

   logic [0:0] r_state;
   logic [7:0] r_base;
   logic [4:0] r_len;
   logic [4:0] r_cnt;
   logic [4:0] r_cnt_nx;
   logic [7:0] rd_addr_nx;

   // A zero length field encodes a full 16-beat burst.
   function automatic logic [4:0] beats(input logic [3:0] field);
      return (field == 4'd0) ? 5'd16 : {1'b0, field};
   endfunction

   assign AWREADY = (w_state == W_IDLE);
   assign WREADY  = (w_state == W_DATA);
   assign BVALID  = (w_state == W_RESP);
   assign ARREADY = (r_state == R_IDLE);
   assign wstate  = w_state;
   assign rstate  = r_state;

   assign wr_en      = (w_state == W_DATA) && WVALID && (w_cnt < w_len);
   assign wr_addr    = w_base + {3'b000, w_cnt};
   assign r_cnt_nx   = r_cnt + 5'd1;
   assign rd_addr_nx = r_base + {3'b000, r_cnt} + 8'd1;

   always_ff @(posedge clk) begin
      if (a_rst) begin
         w_state <= W_IDLE;
         w_cnt   <= 5'd0;
         BRESP   <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (AWVALID) begin
                  w_base  <= AWADDR[11:4];
                  w_len   <= beats(AWADDR[3:0]);
                  w_cnt   <= 5'd0;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (WVALID) begin
                  if (w_cnt != 5'd31) w_cnt <= w_cnt + 5'd1;
                  if (WLAST) begin
                     BRESP   <= (w_cnt == w_len - 5'd1);
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BRESP   <= 1'b0;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Reset gates the write strobe so an abandoned burst stops touching memory.
   always_ff @(posedge clk) begin
      if (!a_rst && wr_en) mem[wr_addr] <= WDATA;
   end

   always_ff @(posedge clk) begin
      if (a_rst) begin
         r_state <= R_IDLE;
         r_cnt   <= 5'd0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RLAST   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ARVALID) begin
                  r_base  <= ARADDR[11:4];
                  r_len   <= beats(ARADDR[3:0]);
                  r_cnt   <= 5'd0;
                  RDATA   <= mem[ARADDR[11:4]];
                  RVALID  <= 1'b1;
                  RLAST   <= (ARADDR[3:0] == 4'd1);
                  r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  if (!RLAST) begin
                     r_cnt <= r_cnt_nx;
                     RDATA <= mem[rd_addr_nx];
                     RLAST <= (r_cnt_nx == r_len - 5'd1);
                  end else begin
                     RVALID  <= 1'b0;
                     RLAST   <= 1'b0;
                     RDATA   <= '0;
                     r_state <= R_IDLE;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Randomized self-checking bench for axi_burst_slave_mem against a byte-array memory model.
module tb_axi_burst_slave_mem;

   logic       clk = 1'b0;
   logic       a_rst;
   logic       AWVALID, AWREADY;
   logic [11:0] AWADDR;
   logic       WVALID, WREADY;
   logic [7:0] WDATA;
   logic       WLAST;
   logic       BVALID, BREADY, BRESP;
   logic       ARVALID, ARREADY;
   logic [11:0] ARADDR;
   logic       RVALID, RREADY;
   logic [7:0] RDATA;
   logic       RLAST;
   logic [1:0] wstate;
   logic       rstate;

   int checks = 0;
   int failures = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] wbuf [32];

   always #5 clk = ~clk;

   axi_burst_slave_mem dut (
      .clk(clk), .a_rst(a_rst),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST),
      .wstate(wstate), .rstate(rstate)
   );

   function automatic int nbeats_of(input logic [3:0] f);
      return (f == 4'd0) ? 16 : int'(f);
   endfunction

   task automatic do_write(input logic [7:0] base, input logic [3:0] lf, input int n,
                           input bit gaps, input int bstall);
      int t;
      logic exp_resp;
      @(negedge clk);
      AWADDR = {base, lf};
      AWVALID = 1'b1;
      t = 0;
      while (!AWREADY && t < 100) begin @(negedge clk); t++; end
      checks++;
      if (AWREADY !== 1'b1) begin
         failures++; $display("FAIL aw_handshake awready=%b required=1", AWREADY);
      end
      @(negedge clk);
      AWVALID = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            WVALID = 1'b0;
            @(negedge clk);
         end
         WVALID = 1'b1;
         WDATA = wbuf[k];
         WLAST = (k == n - 1);
         checks++;
         if (WREADY !== 1'b1) begin
            failures++; $display("FAIL w_ready beat=%0d wready=%b required=1", k, WREADY);
         end
         @(negedge clk);
         if (k < nbeats_of(lf)) ref_mem[8'(int'(base) + k)] = wbuf[k];
      end
      WVALID = 1'b0;
      WLAST = 1'b0;
      exp_resp = (n == nbeats_of(lf));
      checks++;
      if (BVALID !== 1'b1 || BRESP !== exp_resp || AWREADY !== 1'b0 || wstate !== 2'd2) begin
         failures++;
         $display("FAIL b_resp bvalid=%b bresp=%b awready=%b wstate=%0d required 1 %b 0 2",
                  BVALID, BRESP, AWREADY, wstate, exp_resp);
      end
      for (int s = 0; s < bstall; s++) begin
         @(negedge clk);
         checks++;
         if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin
            failures++;
            $display("FAIL b_stall cycle=%0d bvalid=%b awready=%b required 1 0", s, BVALID, AWREADY);
         end
      end
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
      checks++;
      if (BVALID !== 1'b0 || AWREADY !== 1'b1 || wstate !== 2'd0) begin
         failures++;
         $display("FAIL b_done bvalid=%b awready=%b wstate=%0d required 0 1 0", BVALID, AWREADY, wstate);
      end
   endtask

   task automatic check_beat(input int k, input int n, input logic [7:0] exp);
      checks++;
      if (RVALID !== 1'b1 || RDATA !== exp || RLAST !== (k == n - 1)) begin
         failures++;
         $display("FAIL r_beat k=%0d rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                  k, RVALID, RDATA, RLAST, exp, (k == n - 1));
      end
   endtask

   // mode 0: RREADY always high, 1: stall every other beat, 2: random stalls
   task automatic do_read(input logic [7:0] base, input logic [3:0] lf, input int mode);
      int n;
      int t;
      bit stall;
      logic [7:0] exp;
      n = nbeats_of(lf);
      @(negedge clk);
      ARADDR = {base, lf};
      ARVALID = 1'b1;
      t = 0;
      while (!ARREADY && t < 100) begin @(negedge clk); t++; end
      checks++;
      if (ARREADY !== 1'b1) begin
         failures++; $display("FAIL ar_handshake arready=%b required=1", ARREADY);
      end
      @(negedge clk);
      ARVALID = 1'b0;
      for (int k = 0; k < n; k++) begin
         exp = ref_mem[8'(int'(base) + k)];
         stall = (mode == 1) ? (k % 2 == 1) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
         if (stall) begin
            check_beat(k, n, exp);
            RREADY = 1'b0;
            @(negedge clk);
         end
         check_beat(k, n, exp);
         RREADY = 1'b1;
         @(negedge clk);
         RREADY = 1'b0;
      end
      checks++;
      if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 8'h00 || ARREADY !== 1'b1 || rstate !== 1'b0) begin
         failures++;
         $display("FAIL r_done rvalid=%b rlast=%b rdata=%h arready=%b rstate=%b required 0 0 00 1 0",
                  RVALID, RLAST, RDATA, ARREADY, rstate);
      end
   endtask

   task automatic test_reset();
      a_rst = 1'b1;
      AWVALID = 0; AWADDR = '0; WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;
      ARVALID = 0; ARADDR = '0; RREADY = 0;
      repeat (2) @(negedge clk);
      a_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (AWREADY !== 1 || ARREADY !== 1 || BVALID !== 0 || RVALID !== 0 || RDATA !== 8'h00 ||
          wstate !== 2'd0 || rstate !== 1'b0 || WREADY !== 0 || RLAST !== 0) begin
         failures++;
         $display("FAIL reset aw=%b ar=%b b=%b r=%b rdata=%h ws=%0d rs=%b wr=%b rl=%b required 1 1 0 0 00 0 0 0 0",
                  AWREADY, ARREADY, BVALID, RVALID, RDATA, wstate, rstate, WREADY, RLAST);
      end
   endtask

   task automatic test_fill();
      for (int b = 0; b < 16; b++) begin
         for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
         do_write(8'(b * 16), 4'd0, 16, 1'b0, 0);
      end
   endtask

   task automatic test_four_beat();
      wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3; wbuf[3] = 8'hD4;
      do_write(8'h10, 4'd4, 4, 1'b0, 0);
      do_read(8'h10, 4'd4, 0);
      do_read(8'h10, 4'd4, 1);
   endtask

   task automatic test_wrap_len0();
      for (int k = 0; k < 16; k++) wbuf[k] = 8'(k);
      do_write(8'hFE, 4'd0, 16, 1'b0, 0);
      do_read(8'hFE, 4'd0, 0);
      do_read(8'hF8, 4'd0, 2);
   endtask

   task automatic test_len_error();
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      do_write(8'h20, 4'd3, 2, 1'b0, 0);
      do_read(8'h20, 4'd4, 0);
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      do_write(8'h20, 4'd3, 5, 1'b0, 0);
      do_read(8'h20, 4'd5, 0);
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      ARADDR = {8'h40, 4'd8};
      ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_beat(k, 8, ref_mem[8'(8'h40 + k)]);
         RREADY = 1'b1;
         @(negedge clk);
      end
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      RREADY = 1'b0;
      checks++;
      if (RVALID !== 0 || RDATA !== 8'h00 || RLAST !== 0 || rstate !== 1'b0 || ARREADY !== 1) begin
         failures++;
         $display("FAIL rst_mid_read rvalid=%b rdata=%h rlast=%b rstate=%b arready=%b required 0 00 0 0 1",
                  RVALID, RDATA, RLAST, rstate, ARREADY);
      end
      AWADDR = {8'h60, 4'd8};
      AWVALID = 1'b1;
      @(negedge clk);
      AWVALID = 1'b0;
      for (int k = 0; k < 2; k++) begin
         WVALID = 1'b1; WDATA = 8'h50 + 8'(k); WLAST = 1'b0;
         @(negedge clk);
         ref_mem[8'(8'h60 + k)] = 8'h50 + 8'(k);
      end
      WDATA = 8'hEE;
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      WVALID = 1'b0;
      checks++;
      if (wstate !== 2'd0 || AWREADY !== 1 || BVALID !== 0 || WREADY !== 0) begin
         failures++;
         $display("FAIL rst_mid_write wstate=%0d awready=%b bvalid=%b wready=%b required 0 1 0 0",
                  wstate, AWREADY, BVALID, WREADY);
      end
      do_read(8'h60, 4'd8, 0);
      for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
      do_write(8'h70, 4'd4, 4, 1'b0, 5);
      do_read(8'h70, 4'd4, 0);
   endtask

   task automatic test_concurrent();
      for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
      fork
         do_write(8'h80, 4'd0, 16, 1'b1, 2);
         do_read(8'hC0, 4'd0, 2);
      join
      do_read(8'h80, 4'd0, 0);
   endtask

   task automatic test_random();
      logic [7:0] base;
      logic [3:0] lf;
      int n;
      for (int i = 0; i < 15; i++) begin
         base = 8'($urandom);
         lf = 4'($urandom);
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : nbeats_of(lf);
         for (int k = 0; k < 32; k++) wbuf[k] = 8'($urandom);
         do_write(base, lf, n, 1'b1, int'($urandom_range(0, 3)));
         do_read(base, lf, 2);
         do_read(8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_four_beat();
      test_wrap_len0();
      test_len_error();
      test_reset_mid_burst();
      test_concurrent();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_burst_slave_mem.md
Name: axi_burst_slave_mem

Overview:
- Responder end of the team's 8-bit burst AXI-style bus. It accepts the write-address, write-data and write-response channels and the read-address and read-data channels driven by the master, and backs them with a 256x8 byte memory.
- Address encoding matches the master: ADDR[11:4] is the byte base address and ADDR[3:0] is the beat count.
- Write and read paths are independent state machines sharing one memory. It is the bench target and the on-chip scratch store for master transactions.

Parameters:
- MEM_DEPTH, 256, number of bytes. Fixed by the 8-bit base field; do not change.
- DATA_W, 8, data beat width.

Ports:
- clk  in  1  rising-edge clock
- a_rst  in  1  reset, synchronous, active-high
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  12  {base[7:0], len[3:0]}
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  8  write data beat
- WLAST  in  1  final write beat
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  1  1=OK, 0=length error
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARADDR  in  12  {base[7:0], len[3:0]}
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  8  read data beat
- RLAST  out  1  final read beat
- wstate  out  2  write FSM state (debug)
- rstate  out  1  read FSM state (debug)

Behaviour:
- Reset: one clock, synchronous and active-high. a_rst is sampled on the rising edge of clk only.
- Reset values: wstate=W_IDLE, rstate=R_IDLE, AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, BRESP=0, RVALID=0, RDATA=0, RLAST=0, all counters 0.
- Memory contents are not reset. Reset mid-burst abandons the burst with no further memory writes; any beats already written remain.
- Beat count: len 1..15 means that many beats; len=0 means 16 beats. Keep the count internally in 5 bits.
- Address arithmetic: beat k targets byte (base+k) mod 256, so a burst wraps from 0xFF to 0x00.
- Ready signals are decoded combinationally from state:
  - AWREADY=(wstate==W_IDLE)
  - WREADY=(wstate==W_DATA)
  - ARREADY=(rstate==R_IDLE)
- Write FSM:
  - W_IDLE(0): on AWVALID&AWREADY, latch base and len, clear beat counter wcnt, go to W_DATA.
  - W_DATA(1): each WVALID&WREADY edge does the following:
    - If wcnt<len, write mem[base+wcnt]=WDATA. Beats beyond len are accepted and discarded.
    - wcnt increments, saturating at 31.
    - If WLAST is set, latch BRESP=(wcnt==len-1) and go to W_RESP.
  - W_RESP(2): BVALID=1 with BRESP held. On BVALID&BREADY, clear BVALID and go to W_IDLE. No new AW is accepted before that edge.
- Read FSM:
  - R_IDLE(0): on ARVALID&ARREADY, latch base and len, set rcnt=0, and on the same edge load RDATA=mem[ARADDR[11:4]], RVALID=1, RLAST=(len==1). Go to R_DATA. First beat is valid on the cycle after the AR handshake.
  - R_DATA(1): RDATA, RVALID and RLAST hold stable while RREADY=0.
    - On RVALID&RREADY with RLAST=0: rcnt++, RDATA=mem[base+rcnt+1], RLAST=(rcnt+1==len-1).
    - On RVALID&RREADY with RLAST=1: RVALID=0, RLAST=0, RDATA=0, go to R_IDLE.
  - Throughput is one beat per cycle when RREADY is held high.
- Read/write collision: same byte on the same edge returns the old value (registered read). The write lands the same edge.
- Concurrency: the write and read channels operate concurrently and independently of each other.
- Unused outputs in each state are held at 0.

Test Plan:
- Reset: hold a_rst=1 for 2 cycles, then release -> AWREADY=1, ARREADY=1, BVALID=0, RVALID=0, RDATA=0, wstate=0, rstate=0.
- 4-beat write: AWADDR=0x104, WDATA 0xA1,0xB2,0xC3,0xD4 with WLAST on beat 4, BREADY=1 -> mem[0x10..0x13] written, BVALID=1 with BRESP=1 for one cycle, then AWREADY=1.
- 4-beat read: ARADDR=0x104 with RREADY=1 -> RDATA 0xA1,0xB2,0xC3,0xD4 on 4 consecutive cycles starting the cycle after the AR handshake, RLAST=1 only on 0xD4. Repeat with RREADY toggled 1,0,1,0 -> data held stable across stalls.
- Wrap plus len=0: write AWADDR=0xFE0 with 16 beats 0x00..0x0F -> mem[0xFE]=0x00, mem[0xFF]=0x01, mem[0x00]=0x02 ... mem[0x0D]=0x0F, BRESP=1. Read ARADDR=0xFE0 -> 16 beats, RLAST on the 16th.
- Length error: AWADDR=0x203 with WLAST on beat 2 -> BRESP=0, only mem[0x20..0x21] written. Repeat with 5 beats, WLAST on beat 5 -> BRESP=0, mem[0x23] untouched.
- Reset mid-burst plus BREADY stall: assert a_rst after 2 beats of an 8-beat read -> RVALID=0 the next cycle. Then a write with BREADY=0 for 5 cycles -> BVALID stays 1 and AWREADY stays 0 until BREADY=1.
